// File: rtl/phase_seq_pkg.sv
// Shared state encoding and default sizing for the frame phase sequencer.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PAUSE = 2'd3
  } phase_state_t;

  localparam int DEF_N_STAGES    = 3;
  localparam int DEF_FRAME_W     = 24;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int DEF_FCNT_W      = 16;

endpackage

// File: rtl/frame_timer.sv
// Frame period timer: down-counter loaded at frame start, terminal count marks the
// end of the period, then saturates. Also owns the sticky overrun flag.
module frame_timer #(
  parameter int FRAME_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start_i,
  input  logic               in_frame_i,
  input  logic               clr_i,
  input  logic [FRAME_W-1:0] div_i,
  output logic               elapsed_o,
  output logic               overrun_o
);

  logic [FRAME_W-1:0] cnt_q;
  logic               armed_q;
  logic               expired_q;
  logic               overrun_q;
  logic               marker;

  assign marker    = armed_q && (cnt_q == '0);
  assign elapsed_o = marker || expired_q;
  assign overrun_o = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      expired_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (ena) begin
      if (start_i) begin
        // A zero period means unpaced: the period counts as already elapsed.
        cnt_q     <= (div_i == '0) ? '0 : div_i - 1'b1;
        armed_q   <= (div_i != '0);
        expired_q <= (div_i == '0);
      end else if (marker) begin
        armed_q   <= 1'b0;
        expired_q <= 1'b1;
      end else if (armed_q) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (marker && in_frame_i)
        overrun_q <= 1'b1;
      else if (clr_i)
        overrun_q <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Round-robin stage scheduler with frame pacing, per-stage watchdog and pause/step.
//   state    | meaning
//   ST_IDLE  | after reset, starts the first frame on the first enabled edge
//   ST_RUN   | one stage enabled, waiting for its done or the watchdog
//   ST_WAIT  | frame finished early, waiting for the frame period to elapse
//   ST_PAUSE | frame finished with pause requested, waiting for step or unpause
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FCNT_W      = DEF_FCNT_W,
  localparam int SW         = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [FRAME_W-1:0]  frame_div_i,
  input  logic                pause_i,
  input  logic                step_i,
  input  logic                clr_i,
  input  logic [N_STAGES-1:0] done_i,
  output logic [N_STAGES-1:0] en_o,
  output logic [SW-1:0]       stage_o,
  output logic                frame_tick_o,
  output logic [FCNT_W-1:0]   frame_cnt_o,
  output logic                timeout_o,
  output logic [SW-1:0]       timeout_stage_o,
  output logic                overrun_o
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [SW-1:0]   LAST_STAGE = SW'(N_STAGES - 1);

  phase_state_t        state_q, state_nxt;
  logic [N_STAGES-1:0] en_q, en_nxt;
  logic [SW-1:0]       stage_q, stage_nxt;
  logic                tick_q, tick_nxt;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [WD_W-1:0]     wd_q;
  logic                timeout_q;
  logic [SW-1:0]       tstage_q;

  logic done_hit, wd_fire, adv, frame_end;
  logic frame_start, stage_entry, elapsed;

  // en_q is one-hot in RUN and zero elsewhere, so this only sees the active stage.
  assign done_hit  = |(done_i & en_q);
  assign wd_fire   = (TIMEOUT_CYC != 0) && (state_q == ST_RUN) && (wd_q == '0) && !done_hit;
  assign adv       = (state_q == ST_RUN) && (done_hit || wd_fire);
  assign frame_end = adv && (stage_q == LAST_STAGE);

  frame_timer #(
    .FRAME_W (FRAME_W)
  ) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start_i    (frame_start),
    .in_frame_i ((state_q == ST_RUN) && !frame_end),
    .clr_i      (clr_i),
    .div_i      (frame_div_i),
    .elapsed_o  (elapsed),
    .overrun_o  (overrun_o)
  );

  always_comb begin
    state_nxt   = state_q;
    en_nxt      = en_q;
    stage_nxt   = stage_q;
    tick_nxt    = 1'b0;
    frame_start = 1'b0;
    stage_entry = 1'b0;
    unique case (state_q)
      ST_IDLE: frame_start = 1'b1;
      ST_RUN: begin
        if (frame_end) begin
          tick_nxt = 1'b1;
          en_nxt   = '0;
          if (pause_i)      state_nxt   = ST_PAUSE;
          else if (elapsed) frame_start = 1'b1;
          else              state_nxt   = ST_WAIT;
        end else if (adv) begin
          en_nxt      = en_q << 1;
          stage_nxt   = stage_q + 1'b1;
          stage_entry = 1'b1;
        end
      end
      ST_WAIT: begin
        if (elapsed) begin
          if (pause_i) state_nxt   = ST_PAUSE;
          else         frame_start = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (step_i)        frame_start = 1'b1;
        else if (!pause_i) state_nxt   = ST_WAIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (frame_start) begin
      state_nxt   = ST_RUN;
      en_nxt      = N_STAGES'(1);
      stage_nxt   = '0;
      stage_entry = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      stage_q   <= '0;
      tick_q    <= 1'b0;
      fcnt_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      tstage_q  <= '0;
    end else if (ena) begin
      state_q <= state_nxt;
      en_q    <= en_nxt;
      stage_q <= stage_nxt;
      tick_q  <= tick_nxt;
      if (frame_end)
        fcnt_q <= fcnt_q + 1'b1;
      if (stage_entry)
        wd_q <= WD_LOAD;
      else if ((state_q == ST_RUN) && (wd_q != '0))
        wd_q <= wd_q - 1'b1;
      if (wd_fire) begin
        timeout_q <= 1'b1;
        tstage_q  <= stage_q;
      end else if (clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign en_o            = en_q;
  assign stage_o         = stage_q;
  assign frame_tick_o    = tick_q;
  assign frame_cnt_o     = fcnt_q;
  assign timeout_o       = timeout_q;
  assign timeout_stage_o = tstage_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus randomized runs against a
// cycle-age reference model of the scheduling rules.
module tb_phase_sequencer;

  localparam int N  = 3;
  localparam int FW = 24;
  localparam int TO = 16;
  localparam int CW = 16;
  localparam int SW = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_PAUSE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [FW-1:0] frame_div_i = '0;
  logic          pause_i = 1'b0;
  logic          step_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [N-1:0]  done_i = '0;
  logic [N-1:0]  en_o;
  logic [SW-1:0] stage_o;
  logic          frame_tick_o;
  logic [CW-1:0] frame_cnt_o;
  logic          timeout_o;
  logic [SW-1:0] timeout_stage_o;
  logic          overrun_o;

  always #5 clk = ~clk;

  phase_sequencer #(
    .N_STAGES    (N),
    .FRAME_W     (FW),
    .TIMEOUT_CYC (TO),
    .FCNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .frame_div_i     (frame_div_i),
    .pause_i         (pause_i),
    .step_i          (step_i),
    .clr_i           (clr_i),
    .done_i          (done_i),
    .en_o            (en_o),
    .stage_o         (stage_o),
    .frame_tick_o    (frame_tick_o),
    .frame_cnt_o     (frame_cnt_o),
    .timeout_o       (timeout_o),
    .timeout_stage_o (timeout_stage_o),
    .overrun_o       (overrun_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: frame/stage ages in cycles, rules applied directly
  int          m_mode, m_stage, m_sage, m_fage, m_div, m_tst;
  bit          m_tick, m_to, m_ov;
  logic [15:0] m_fcnt;

  // stage responder: done after lat[k] cycles of enable, -1 = never
  int           lat [N];
  int           resp_age;
  logic [N-1:0] prev_en;
  bit           rnd_on = 1'b0;

  task automatic model_reset();
    m_mode = M_IDLE; m_stage = 0; m_sage = 0; m_fage = 0; m_div = 0; m_tst = 0;
    m_tick = 0; m_to = 0; m_ov = 0; m_fcnt = '0;
  endtask

  task automatic model_step();
    int fage_pre;
    bit elapsed, hit, fire, start, to_set, ov_set;
    fage_pre = m_fage;
    elapsed  = (m_div == 0) || (fage_pre >= m_div - 1);
    start = 0; to_set = 0; ov_set = 0; hit = 0; fire = 0;
    m_tick = 0;
    case (m_mode)
      M_IDLE: start = 1;
      M_RUN: begin
        hit  = done_i[m_stage];
        fire = (m_sage == TO - 1) && !hit;
        if (m_div != 0 && fage_pre == m_div - 1 && !((hit || fire) && m_stage == N - 1))
          ov_set = 1;
        if (fire) begin
          to_set = 1;
          m_tst  = m_stage;
        end
        if (hit || fire) begin
          if (m_stage == N - 1) begin
            m_tick = 1;
            m_fcnt = m_fcnt + 16'd1;
            if (pause_i)      m_mode = M_PAUSE;
            else if (elapsed) start  = 1;
            else              m_mode = M_WAIT;
          end else begin
            m_stage++;
            m_sage = 0;
          end
        end else begin
          m_sage++;
        end
      end
      M_WAIT: if (elapsed) begin
        if (pause_i) m_mode = M_PAUSE;
        else         start  = 1;
      end
      default: begin
        if (step_i)        start  = 1;
        else if (!pause_i) m_mode = M_WAIT;
      end
    endcase
    if (start) begin
      m_mode = M_RUN; m_stage = 0; m_sage = 0; m_fage = 0; m_div = int'(frame_div_i);
    end else if (m_fage < (1 << 30)) begin
      m_fage++;
    end
    if (to_set)     m_to = 1;
    else if (clr_i) m_to = 0;
    if (ov_set)     m_ov = 1;
    else if (clr_i) m_ov = 0;
  endtask

  task automatic compare_all();
    logic [31:0] exp_en;
    exp_en = (m_mode == M_RUN) ? (32'd1 << m_stage) : 32'd0;
    check("en_o", 32'(en_o), exp_en);
    check("stage_o", 32'(stage_o), 32'(m_stage));
    check("frame_tick_o", 32'(frame_tick_o), 32'(m_tick));
    check("frame_cnt_o", 32'(frame_cnt_o), 32'(m_fcnt));
    check("timeout_o", 32'(timeout_o), 32'(m_to));
    check("timeout_stage_o", 32'(timeout_stage_o), 32'(m_tst));
    check("overrun_o", 32'(overrun_o), 32'(m_ov));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    if (ena) model_step();
    @(negedge clk);
    compare_all();
    if (rnd_on) begin
      ena   = ($urandom_range(0, 99) >= 8);
      if ($urandom_range(0, 99) < 4) pause_i = ~pause_i;
      step_i = ($urandom_range(0, 99) < 6);
      clr_i  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) frame_div_i = FW'($urandom_range(0, 40));
      if ($urandom_range(0, 99) < 3) lat[$urandom_range(0, N - 1)] = $urandom_range(0, 6);
    end
    if (en_o !== prev_en) resp_age = 0;
    else                  resp_age++;
    prev_en = en_o;
    done_i  = rnd_on ? N'($urandom_range(0, (1 << N) - 1)) : '0;
    for (int k = 0; k < N; k++)
      if (en_o[k]) done_i[k] = (lat[k] >= 0) && (resp_age >= lat[k]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; pause_i = 1'b0; step_i = 1'b0; clr_i = 1'b0; done_i = '0;
    prev_en = '0; resp_age = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
  endtask

  task automatic wait_en(input logic [N-1:0] want, input int budget, input string tag);
    int n = 0;
    while (en_o !== want && n < budget) begin
      step_cycle();
      n++;
    end
    check(tag, 32'(en_o), 32'(want));
  endtask

  initial begin
    int cnt;

    // unpaced, immediate answers: one stage per cycle
    frame_div_i = '0; set_lat(0, 0, 0);
    do_reset();
    check("reset_en", 32'(en_o), 32'd0);
    for (int i = 0; i < 31; i++) step_cycle();
    check("t1_fcnt_after_30", 32'(frame_cnt_o), 32'd10);

    // paced at 100: three active cycles then 97 idle per frame
    frame_div_i = FW'(100);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step_cycle();
      if (en_o == '0) cnt++;
    end
    check("t2_idle_cycles", 32'(cnt), 32'd194);
    check("t2_overrun", 32'(overrun_o), 32'd0);

    // stage 1 never answers: watchdog advances after exactly TO cycles
    frame_div_i = '0; set_lat(0, -1, 0);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step_cycle();
      if (en_o[1]) cnt++;
    end
    check("t3_en1_len", 32'(cnt), 32'(TO));
    check("t3_timeout", 32'(timeout_o), 32'd1);
    check("t3_timeout_stage", 32'(timeout_stage_o), 32'd1);
    lat[1] = 0;
    clr_i = 1'b1;
    step_cycle();
    clr_i = 1'b0;
    check("t3_clr", 32'(timeout_o), 32'd0);
    for (int i = 0; i < 10; i++) step_cycle();

    // frame longer than the period: overrun, back-to-back frames
    frame_div_i = FW'(10); set_lat(5, 5, 5);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step_cycle();
      if (en_o == '0) cnt++;
    end
    check("t4_overrun", 32'(overrun_o), 32'd1);
    check("t4_gap", 32'(cnt), 32'd0);

    // pause mid-frame, then single step
    frame_div_i = '0; set_lat(1, 1, 1);
    do_reset();
    wait_en(3'b010, 20, "t5_wait_stage1");
    pause_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      if (frame_tick_o) cnt++;
    end
    check("t5_ticks_pause", 32'(cnt), 32'd1);
    check("t5_en_paused", 32'(en_o), 32'd0);
    step_i = 1'b1;
    cnt = 0;
    step_cycle();
    step_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      if (frame_tick_o) cnt++;
    end
    check("t5_ticks_step", 32'(cnt), 32'd1);
    check("t5_en_after_step", 32'(en_o), 32'd0);
    pause_i = 1'b0;

    // async reset mid-stage, then an ena freeze
    set_lat(2, 2, 2);
    do_reset();
    wait_en(3'b010, 20, "t6_wait_stage1");
    #2 rst_n = 1'b0;
    #1 check("t6_async_en", 32'(en_o), 32'd0);
    do_reset();
    for (int i = 0; i < 10; i++) step_cycle();
    ena = 1'b0;
    for (int i = 0; i < 20; i++) step_cycle();
    ena = 1'b1;
    for (int i = 0; i < 20; i++) step_cycle();

    // randomized runs
    for (int p = 0; p < 8; p++) begin
      rnd_on = 1'b0;
      frame_div_i = ($urandom_range(0, 3) == 0) ? '0 : FW'($urandom_range(1, 40));
      for (int k = 0; k < N; k++) lat[k] = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) lat[$urandom_range(0, N - 1)] = -1;
      do_reset();
      rnd_on = 1'b1;
      for (int i = 0; i < 400; i++) step_cycle();
    end
    rnd_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
